// File: rtl/power_domain_sequencer.sv
// Per-domain power sequencer: one independent OFF/PWR_UP/ISO_REL/ON/DRAIN/FAULT
// machine per channel driving switch enable, isolation clamp and domain reset.
module power_domain_sequencer #(
  parameter int NUM_CHANNELS       = 4,
  parameter int ISO_DELAY_CYCLES   = 2,
  parameter int PWR_TIMEOUT_CYCLES = 64
) (
  input  logic                    clock,
  input  logic                    async_resetn,
  input  logic [NUM_CHANNELS-1:0] enable_req,
  output logic [NUM_CHANNELS-1:0] enable_ack,
  input  logic [NUM_CHANNELS-1:0] power_good,
  output logic [NUM_CHANNELS-1:0] power_switch_en,
  output logic [NUM_CHANNELS-1:0] isolation,
  output logic [NUM_CHANNELS-1:0] domain_resetn,
  output logic [NUM_CHANNELS-1:0] fault,
  input  logic [NUM_CHANNELS-1:0] fault_clear
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWR_UP  = 3'd1,
    ST_ISO_REL = 3'd2,
    ST_ON      = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  localparam logic [7:0] ISO_LAST = 8'(ISO_DELAY_CYCLES - 1);
  localparam logic [7:0] TMO_LAST = 8'(PWR_TIMEOUT_CYCLES - 1);

  logic [NUM_CHANNELS-1:0] req_r;
  logic [NUM_CHANNELS-1:0] clr_r;
  logic [NUM_CHANNELS-1:0] good_meta_r;
  logic [NUM_CHANNELS-1:0] good_sync_r;

  // Input capture; power_good comes from another domain so it gets two flops
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      req_r       <= {NUM_CHANNELS{1'b0}};
      clr_r       <= {NUM_CHANNELS{1'b0}};
      good_meta_r <= {NUM_CHANNELS{1'b0}};
      good_sync_r <= {NUM_CHANNELS{1'b0}};
    end else begin
      req_r       <= enable_req;
      clr_r       <= fault_clear;
      good_meta_r <= power_good;
      good_sync_r <= good_meta_r;
    end
  end

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    state_e     state_r;
    state_e     state_next_s;
    logic [7:0] dwell_r;
    logic       psw_s;
    logic       iso_s;
    logic       rstn_s;
    logic       ack_s;
    logic       flt_s;

    // State register; dwell restarts on every state change and saturates
    always_ff @(posedge clock or negedge async_resetn) begin
      if (!async_resetn) begin
        state_r <= ST_OFF;
        dwell_r <= 8'd0;
      end else if (state_next_s != state_r) begin
        state_r <= state_next_s;
        dwell_r <= 8'd0;
      end else if (dwell_r != 8'hFF) begin
        state_r <= state_r;
        dwell_r <= dwell_r + 8'd1;
      end else begin
        state_r <= state_r;
        dwell_r <= dwell_r;
      end
    end

    // Next-state logic; a dropped request wins over progress, lost power wins in ON
    always_comb begin
      state_next_s = state_r;
      case (state_r)
        ST_OFF: begin
          if (req_r[ch]) state_next_s = ST_PWR_UP;
          else           state_next_s = ST_OFF;
        end
        ST_PWR_UP: begin
          if (!req_r[ch])              state_next_s = ST_DRAIN;
          else if (good_sync_r[ch])    state_next_s = ST_ISO_REL;
          else if (dwell_r == TMO_LAST) state_next_s = ST_FAULT;
          else                         state_next_s = ST_PWR_UP;
        end
        ST_ISO_REL: begin
          if (!req_r[ch])               state_next_s = ST_DRAIN;
          else if (!good_sync_r[ch])    state_next_s = ST_FAULT;
          else if (dwell_r == ISO_LAST) state_next_s = ST_ON;
          else                          state_next_s = ST_ISO_REL;
        end
        ST_ON: begin
          if (!good_sync_r[ch]) state_next_s = ST_FAULT;
          else if (!req_r[ch])  state_next_s = ST_DRAIN;
          else                  state_next_s = ST_ON;
        end
        ST_DRAIN: begin
          if (dwell_r == ISO_LAST) state_next_s = ST_OFF;
          else                     state_next_s = ST_DRAIN;
        end
        ST_FAULT: begin
          if (clr_r[ch] && !req_r[ch]) state_next_s = ST_OFF;
          else                         state_next_s = ST_FAULT;
        end
        default: state_next_s = ST_FAULT;
      endcase
    end

    // Moore output decode; unknown encodings fall back to the isolated, unpowered set
    always_comb begin
      psw_s  = 1'b0;
      iso_s  = 1'b1;
      rstn_s = 1'b0;
      case (state_r)
        ST_OFF:     begin psw_s = 1'b0; iso_s = 1'b1; rstn_s = 1'b0; end
        ST_PWR_UP:  begin psw_s = 1'b1; iso_s = 1'b1; rstn_s = 1'b0; end
        ST_ISO_REL: begin psw_s = 1'b1; iso_s = 1'b0; rstn_s = 1'b0; end
        ST_ON:      begin psw_s = 1'b1; iso_s = 1'b0; rstn_s = 1'b1; end
        ST_DRAIN:   begin psw_s = 1'b1; iso_s = 1'b1; rstn_s = 1'b0; end
        ST_FAULT:   begin psw_s = 1'b0; iso_s = 1'b1; rstn_s = 1'b0; end
        default:    begin psw_s = 1'b0; iso_s = 1'b1; rstn_s = 1'b0; end
      endcase
      ack_s = (state_r == ST_ON);
      flt_s = (state_r == ST_FAULT);
    end

    assign power_switch_en[ch] = psw_s;
    assign isolation[ch]       = iso_s;
    assign domain_resetn[ch]   = rstn_s;
    assign enable_ack[ch]      = ack_s;
    assign fault[ch]           = flt_s;
  end

endmodule

// File: doc/power_domain_sequencer.md
POWER_DOMAIN_SEQUENCER -- requirements
Module: power_domain_sequencer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of independent power domains (1..16).
REQ-002 SHALL have parameter ISO_DELAY_CYCLES, default 2, isolation/reset settle hold in cycles (1..255).
REQ-003 SHALL have parameter PWR_TIMEOUT_CYCLES, default 64, max cycles waiting for power_good (1..255).
REQ-004 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port async_resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable_req  input  NUM_CHANNELS  per-domain power-on request (level).
REQ-007 SHALL have port enable_ack  output  NUM_CHANNELS  per-domain fully-on acknowledge.
REQ-008 SHALL have port power_good  input  NUM_CHANNELS  asynchronous power-switch status from domain.
REQ-009 SHALL have port power_switch_en  output  NUM_CHANNELS  power switch enable.
REQ-010 SHALL have port isolation  output  NUM_CHANNELS  clamp enable, 1 = isolated.
REQ-011 SHALL have port domain_resetn  output  NUM_CHANNELS  active-low reset into domain.
REQ-012 SHALL have port fault  output  NUM_CHANNELS  sticky per-domain fault flag.
REQ-013 SHALL have port fault_clear  input  NUM_CHANNELS  per-domain fault clear request (level).

Function
REQ-014 SHALL run one independent channel instance per bit; no interaction between channels.
REQ-015 SHALL register enable_req and fault_clear once, and pass power_good through a 2-flop synchronizer, before FSM use.
REQ-016 SHALL implement per-channel FSM states OFF, PWR_UP, ISO_REL, ON, DRAIN, FAULT, with an 8-bit dwell counter cleared on every state change.
REQ-017 SHALL drive outputs as Moore functions of state: OFF psw=0 iso=1 rstn=0; PWR_UP psw=1 iso=1 rstn=0; ISO_REL psw=1 iso=0 rstn=0; ON psw=1 iso=0 rstn=1; DRAIN psw=1 iso=1 rstn=0; FAULT psw=0 iso=1 rstn=0.
REQ-018 SHALL assert enable_ack only in ON and fault only in FAULT.
REQ-019 SHALL transition OFF->PWR_UP when registered req=1 and FAULT is not held.
REQ-020 SHALL transition PWR_UP->ISO_REL when synced good=1; ->DRAIN when registered req=0 (takes priority); ->FAULT when counter reaches PWR_TIMEOUT_CYCLES-1 with good=0.
REQ-021 SHALL hold ISO_REL exactly ISO_DELAY_CYCLES cycles then go ON; ->DRAIN if registered req=0 (priority); ->FAULT if synced good=0.
REQ-022 SHALL transition ON->DRAIN when registered req=0; ON->FAULT when synced good=0 (FAULT priority over DRAIN).
REQ-023 SHALL hold DRAIN exactly ISO_DELAY_CYCLES cycles then go OFF, ignoring req during DRAIN.
REQ-024 SHALL leave FAULT for OFF only when registered fault_clear=1 and registered req=0 in the same cycle.
REQ-025 SHALL guarantee ordering: isolation asserts no later than domain_resetn falls, and power_switch_en never falls unless isolation=1 and domain_resetn=0.

Reset
REQ-026 SHALL, while async_resetn=0, force every channel to OFF, counters and sync/req registers to 0, enable_ack=0, power_switch_en=0, isolation=all ones, domain_resetn=0, fault=0.
REQ-027 SHALL treat reset mid-sequence (any state) identically to power-on reset, without passing through DRAIN.

Verification
REQ-028 SHALL cover power-up: defaults, power_good[0] tied 1, enable_req[0] rises -> enable_ack[0]=1 exactly ISO_DELAY_CYCLES+2 edges after first edge sampling req=1 (4 edges at default); isolation[0] falls 2 edges before ack.
REQ-029 SHALL cover power-down: from ON, enable_req[0]=0 -> isolation[0]=1 and domain_resetn[0]=0 together, power_switch_en[0]=0 exactly 2 cycles later, ack falls first.
REQ-030 SHALL cover timeout: power_good[1] held 0, enable_req[1]=1 -> fault[1]=1 after 64 cycles in PWR_UP, psw[1]=0; fault_clear[1] with req still 1 -> fault stays; req=0 then clear -> OFF.
REQ-031 SHALL cover brown-out: channel ON, power_good[2] drops -> FAULT within 3 cycles, isolation[2]=1, ack[2]=0.
REQ-032 SHALL cover abort and independence: enable_req[3] pulsed 1 for 2 cycles -> DRAIN, ack[3] never high; other channels' outputs unchanged throughout.
REQ-033 SHALL cover reset mid-ON: async_resetn low -> all outputs return to reset values asynchronously, before the next clock edge.
